// File: rtl/spw_rx_credit_buffer_if.sv
// Receive-side N-char bus, read port and FCT credit handshake for the SpaceWire RX buffer.
// Latency: none, wires only.
// Backpressure: none here; flow control is enforced by the credit handshake carried on this bus.
interface spw_rx_credit_buffer_if #(
    parameter int AW = 6
);
    logic          link_run;
    logic          wr_en;
    logic [8:0]    wr_data;
    logic          rd_en;
    logic [8:0]    rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic [AW-1:0] credit;
    logic          fct_req;
    logic          fct_ack;
    logic          credit_error;

    // Drives the buffer: decoder writes, consumer reads, TX acks, link state
    modport master (
        output link_run, wr_en, wr_data, rd_en, fct_ack,
        input  rd_data, rd_valid, count, credit, fct_req, credit_error
    );

    // The buffer itself
    modport slave (
        input  link_run, wr_en, wr_data, rd_en, fct_ack,
        output rd_data, rd_valid, count, credit, fct_req, credit_error
    );
endinterface

// File: rtl/spw_rx_credit_buffer.sv
// SpaceWire RX N-char FIFO with far-end credit accounting and FCT request generation.
// Latency: write to rd_valid/rd_data 1 cycle (FWFT); count/credit/fct_req update at the next edge.
// Backpressure: none toward the link; writes beyond granted credit or space are dropped and flagged.
module spw_rx_credit_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input logic              pclk_sys,
    input logic              reset,
    spw_rx_credit_buffer_if.slave bus
);
    localparam int            CW       = AW + 2;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] REQ_MAX  = AW'(48);
    localparam logic [AW-1:0] FCT_STEP = AW'(8);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] credit_q, credit_d;
    logic          fct_req_q, fct_req_d;
    logic          err_q, err_d;
    logic [8:0]    mem_q [DEPTH];

    logic          wr_ok;
    logic          wr_viol;
    logic          rd_ok;
    logic          ack_ok;
    logic          grant;
    logic [CW-1:0] room_sum;

    // A write is only legal while the far end holds credit and a slot is free;
    // anything else is a far-end protocol violation.
    assign wr_ok    = bus.link_run && bus.wr_en && (credit_q != '0) && (count_q < DEPTH_C);
    assign wr_viol  = bus.link_run && bus.wr_en && !wr_ok;
    assign rd_ok    = bus.link_run && bus.rd_en && (count_q != '0);
    assign ack_ok   = bus.link_run && bus.fct_ack && fct_req_q;

    // Another FCT may be promised only if 8 more chars fit on top of everything
    // already stored plus everything already promised, and credit stays <= 56.
    assign room_sum = CW'(count_q) + CW'(credit_q) + CW'(8);
    assign grant    = bus.link_run && (credit_q <= REQ_MAX) && (room_sum <= CW'(DEPTH));

    // Next-state for pointers, occupancy, credit, FCT request and sticky error
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        credit_d  = credit_q;
        fct_req_d = fct_req_q;
        err_d     = err_q;
        if (!bus.link_run) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            credit_d  = '0;
            fct_req_d = 1'b0;
            err_d     = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            credit_d = credit_q - {{(AW-1){1'b0}}, wr_ok} + (ack_ok ? FCT_STEP : '0);
            if (wr_viol) begin
                err_d = 1'b1;
            end
            // Dropping for a cycle after each ack lets the request re-evaluate
            // against the credit the ack just added, so one grant never yields two FCTs.
            fct_req_d = grant && !bus.fct_ack;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge pclk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credit_q  <= '0;
            fct_req_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credit_q  <= credit_d;
            fct_req_q <= fct_req_d;
            err_q     <= err_d;
        end
    end

    // Storage array; contents need no reset since rd_valid gates rd_data
    always_ff @(posedge pclk_sys) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = mem_q[rd_ptr_q];
    assign bus.rd_valid     = (count_q != '0);
    assign bus.count        = count_q;
    assign bus.credit       = credit_q;
    assign bus.fct_req      = fct_req_q;
    assign bus.credit_error = err_q;
endmodule

// File: tb/tb_spw_rx_credit_buffer.sv
// Self-checking bench for spw_rx_credit_buffer: directed plan steps then randomized traffic.
// Latency: outputs compared 1 time unit after every rising edge against a queue-based model.
// Backpressure: stimulus intentionally over-writes to provoke credit violations.
module tb_spw_rx_credit_buffer;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic pclk_sys = 1'b0;
    logic reset;

    always #5 pclk_sys = ~pclk_sys;

    spw_rx_credit_buffer_if #(.AW(AW)) bus ();

    spw_rx_credit_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .pclk_sys (pclk_sys),
        .reset    (reset),
        .bus      (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO contents, credit the far end holds, FCT request and sticky error
    logic [8:0] mq[$];
    int         m_credit;
    bit         m_req;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_credit = 0;
        m_req    = 1'b0;
        m_err    = 1'b0;
    endtask

    // Apply the behavioural rules to the inputs present just before the edge
    task automatic model_step();
        bit acc, rd, g;
        int sz;
        if (!bus.link_run) begin
            model_clear();
        end else begin
            sz  = mq.size();
            acc = bus.wr_en && (m_credit != 0) && (sz < DEPTH);
            rd  = bus.rd_en && (sz > 0);
            g   = (m_credit <= 48) && (sz + m_credit + 8 <= DEPTH);
            if (bus.wr_en && !acc) m_err = 1'b1;
            if (bus.fct_ack && m_req) m_credit = m_credit + 8;
            if (acc) m_credit = m_credit - 1;
            if (rd) void'(mq.pop_front());
            if (acc) mq.push_back(bus.wr_data);
            m_req = g && !bus.fct_ack;
        end
    endtask

    task automatic check_all();
        chk("count", bus.count, mq.size());
        chk("credit", bus.credit, m_credit);
        chk("fct_req", bus.fct_req, m_req);
        chk("credit_error", bus.credit_error, m_err);
        chk("rd_valid", bus.rd_valid, (mq.size() != 0));
        chk("credit_le_56", (bus.credit <= 56), 1);
        if (mq.size() != 0) chk("rd_data", bus.rd_data, mq[0]);
    endtask

    task automatic tick(input bit we, input logic [8:0] wd, input bit re, input bit ack);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.fct_ack = ack;
        model_step();
        @(posedge pclk_sys);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.fct_ack = 1'b0;
        check_all();
    endtask

    // Ack each request as it appears until n acks have been given (bounded)
    task automatic ack_n(input int n);
        int got = 0;
        for (int c = 0; c < 8 * n + 8 && got < n; c++) begin
            if (m_req) begin
                tick(1'b0, 9'h0, 1'b0, 1'b1);
                got++;
            end else begin
                tick(1'b0, 9'h0, 1'b0, 1'b0);
            end
        end
        chk("ack_count", got, n);
    endtask

    // Flush the link, bring it back to Run and confirm the first request
    task automatic relink();
        bus.link_run = 1'b0;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        bus.link_run = 1'b1;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        chk("run_rise_req", bus.fct_req, 1);
    endtask

    // Reach count=20, credit=0, credit_error=1
    task automatic setup_err_state();
        relink();
        ack_n(3);
        for (int i = 0; i < 24; i++) tick(1'b1, 9'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 9'h0, 1'b1, 1'b0);
        tick(1'b1, 9'h0AA, 1'b0, 1'b0);
        chk("err_setup_count", bus.count, 20);
        chk("err_setup_err", bus.credit_error, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit we, re, ack;

        // Reset
        reset        = 1'b1;
        bus.link_run = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 9'h0;
        bus.rd_en    = 1'b0;
        bus.fct_ack  = 1'b0;
        model_clear();
        #12;
        chk("rst_count", bus.count, 0);
        chk("rst_credit", bus.credit, 0);
        chk("rst_fct_req", bus.fct_req, 0);
        chk("rst_credit_error", bus.credit_error, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        @(negedge pclk_sys);
        reset = 1'b0;

        // Link up, ack every request: credit climbs to 56 then requests stop
        bus.link_run = 1'b1;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        chk("run_rise_req", bus.fct_req, 1);
        ack_n(7);
        chk("credit_56", bus.credit, 56);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 9'h0, 1'b0, 1'b0);
            chk("idle_req_low", bus.fct_req, 0);
        end

        // 8 data chars in order, then read them back
        for (int i = 0; i < 8; i++) tick(1'b1, 9'(i), 1'b0, 1'b0);
        chk("credit_48", bus.credit, 48);
        chk("count_8", bus.count, 8);
        chk("req_not_yet", bus.fct_req, 0);
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        chk("req_after_48", bus.fct_req, 1);
        for (int i = 0; i < 8; i++) begin
            chk("order_data", bus.rd_data, i);
            tick(1'b0, 9'h0, 1'b1, 1'b0);
        end
        chk("drained", bus.count, 0);

        // EOP then EEP
        tick(1'b1, 9'h100, 1'b0, 1'b0);
        tick(1'b1, 9'h101, 1'b0, 1'b0);
        chk("ctrl_count_2", bus.count, 2);
        chk("eop", bus.rd_data, 9'h100);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        chk("eep", bus.rd_data, 9'h101);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        chk("ctrl_count_0", bus.count, 0);

        // Fill to 64 with the last grant, then overflow
        relink();
        ack_n(7);
        for (int i = 0; i < 56; i++) tick(1'b1, 9'($urandom), 1'b0, 1'b0);
        chk("fill_count_56", bus.count, 56);
        chk("fill_credit_0", bus.credit, 0);
        chk("fill_req", bus.fct_req, 1);
        tick(1'b0, 9'h0, 1'b0, 1'b1);
        chk("last_grant_credit", bus.credit, 8);
        for (int i = 0; i < 8; i++) tick(1'b1, 9'($urandom), 1'b0, 1'b0);
        chk("full_count", bus.count, 64);
        chk("full_credit", bus.credit, 0);
        tick(1'b1, 9'h055, 1'b0, 1'b0);
        chk("overflow_err", bus.credit_error, 1);
        chk("overflow_count", bus.count, 64);
        tick(1'b1, 9'h056, 1'b1, 1'b0);
        chk("full_rw_count", bus.count, 63);
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, 9'h0, 1'b1, 1'b0);
            chk("full_req_low", bus.fct_req, 0);
        end
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        chk("req_after_reads", bus.fct_req, 1);

        // Ack coinciding with an accepted write at credit 10
        relink();
        ack_n(2);
        for (int i = 0; i < 6; i++) tick(1'b1, 9'(i), 1'b0, 1'b0);
        for (int c = 0; c < 4 && !m_req; c++) tick(1'b0, 9'h0, 1'b0, 1'b0);
        chk("credit_10", bus.credit, 10);
        chk("req_before_ack", bus.fct_req, 1);
        tick(1'b1, 9'h0EE, 1'b0, 1'b1);
        chk("credit_17", bus.credit, 17);
        chk("req_drop_after_ack", bus.fct_req, 0);

        // Link drop mid-stream clears everything and ignores strobes
        setup_err_state();
        bus.link_run = 1'b0;
        tick(1'b1, 9'h011, 1'b1, 1'b1);
        chk("drop_count", bus.count, 0);
        chk("drop_credit", bus.credit, 0);
        chk("drop_req", bus.fct_req, 0);
        chk("drop_err", bus.credit_error, 0);
        chk("drop_rd_valid", bus.rd_valid, 0);

        // Same state, async reset instead
        bus.link_run = 1'b1;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        setup_err_state();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        chk("arst_count", bus.count, 0);
        chk("arst_credit", bus.credit, 0);
        chk("arst_req", bus.fct_req, 0);
        chk("arst_err", bus.credit_error, 0);
        chk("arst_rd_valid", bus.rd_valid, 0);
        @(negedge pclk_sys);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.link_run = ($urandom_range(0, 99) != 0);
            we  = ($urandom_range(0, 1) == 1);
            re  = ($urandom_range(0, 99) < 45);
            ack = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            tick(we, 9'($urandom), re, ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
